// File: rtl/noc_link_pkg.sv
// Shared NoC serial-link definitions: flit/chunk geometry, link typedefs and
// the receive-side assembly state. The link serializer uses the same package.
package noc_link_pkg;
  localparam int FLIT_W     = 64;
  localparam int CHUNK_W    = 4;
  localparam int VC_W       = 2;
  localparam int NCHUNK     = FLIT_W / CHUNK_W;
  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = $clog2(NCHUNK);
  localparam int DROP_W     = 8;

  typedef logic [FLIT_W-1:0]  flit_t;
  typedef logic [VC_W-1:0]    vc_t;
  typedef logic [CHUNK_W-1:0] chunk_t;

  typedef struct packed {
    vc_t   vc;
    flit_t flit;
  } fifo_ent_t;

  typedef enum logic {S_IDLE, S_ASM} asm_state_t;
endpackage

// File: rtl/deserializer_if.sv
// Serial-in / flit-out link bundle between the serial PHY side, the
// deserializer and the router input port.
interface deserializer_if;
  import noc_link_pkg::*;

  chunk_t             data_in;
  logic               valid_in;
  vc_t                vc_in;
  flit_t              flit_out;
  vc_t                flit_vc_out;
  logic               flit_valid_out;
  logic               flit_ready_in;
  logic               busy;
  logic               err_vc_switch;
  logic               err_overflow;
  logic [DROP_W-1:0]  drop_count;

  modport master (
    output data_in, valid_in, vc_in, flit_ready_in,
    input  flit_out, flit_vc_out, flit_valid_out, busy,
           err_vc_switch, err_overflow, drop_count
  );

  modport slave (
    input  data_in, valid_in, vc_in, flit_ready_in,
    output flit_out, flit_vc_out, flit_valid_out, busy,
           err_vc_switch, err_overflow, drop_count
  );
endinterface

// File: rtl/flit_fifo.sv
// Small synchronous FIFO of {vc, flit}; the head entry is read straight out of
// the storage registers. Push while full is accepted only alongside a pop.
module flit_fifo
  import noc_link_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  fifo_ent_t din_i,
  input  logic      pop_i,
  output fifo_ent_t dout_o,
  output logic      full_o,
  output logic      empty_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  fifo_ent_t         mem_q [DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [CW-1:0]     cnt_q;
  logic              do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= ptr_inc(wr_q);
      end
      if (do_pop) rd_q <= ptr_inc(rd_q);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/deserializer.sv
// NoC serial-link receiver: reassembles 4-bit chunks (LS chunk first) into
// 64-bit flits, buffers them for the router and reports dropped flits.
module deserializer
  import noc_link_pkg::*;
(
  input logic           clk,
  input logic           rst,
  deserializer_if.slave link
);
  asm_state_t        state_q, state_d;
  flit_t             asm_q, asm_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  vc_t               vc_q, vc_d;
  logic [DROP_W-1:0] drop_q;
  logic              err_vc_q, err_ovf_q;
  logic              push, vc_err, ovf, full, empty;
  fifo_ent_t         head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      asm_q   <= '0;
      cnt_q   <= '0;
      vc_q    <= '0;
    end else begin
      state_q <= state_d;
      asm_q   <= asm_d;
      cnt_q   <= cnt_d;
      vc_q    <= vc_d;
    end
  end

  // A chunk that arrives idle, or on a different VC mid-flit, always starts a new flit.
  always_comb begin
    state_d = state_q;
    asm_d   = asm_q;
    cnt_d   = cnt_q;
    vc_d    = vc_q;
    push    = 1'b0;
    vc_err  = 1'b0;
    if (link.valid_in) begin
      if (state_q == S_IDLE || link.vc_in != vc_q) begin
        vc_err                = (state_q == S_ASM);
        asm_d[CHUNK_W-1:0]    = link.data_in;
        cnt_d                 = CNT_W'(1);
        vc_d                  = link.vc_in;
        state_d               = S_ASM;
      end else begin
        asm_d[cnt_q*CHUNK_W +: CHUNK_W] = link.data_in;
        if (cnt_q == CNT_W'(NCHUNK - 1)) begin
          push    = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  assign ovf = push && full && !(link.flit_valid_out && link.flit_ready_in);

  flit_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   ('{vc: vc_q, flit: {link.data_in, asm_q[FLIT_W-CHUNK_W-1:0]}}),
    .pop_i   (link.flit_ready_in),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_vc_q  <= 1'b0;
      err_ovf_q <= 1'b0;
      drop_q    <= '0;
    end else begin
      err_vc_q  <= vc_err;
      err_ovf_q <= ovf;
      if ((vc_err || ovf) && drop_q != '1) drop_q <= drop_q + 1'b1;
    end
  end

  assign link.flit_out       = head.flit;
  assign link.flit_vc_out    = head.vc;
  assign link.flit_valid_out = !empty;
  assign link.busy           = (state_q == S_ASM);
  assign link.err_vc_switch  = err_vc_q;
  assign link.err_overflow   = err_ovf_q;
  assign link.drop_count     = drop_q;
endmodule
